// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and controller state encoding.
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4_slice.sv
// Combinational 4-bit ripple-carry adder slice, time-shared by the nibble-serial controller.
module add4_slice
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    co = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit slice, LSB nibble first, carry held
// in a flop between passes; start/done handshake with the result held until next start.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned MSB   = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Bit offset of the active nibble; NIBBLE_W is 4, so the offset is idx shifted by two.
  logic [IDX_W+1:0]    base;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;

  assign base = {idx_q, 2'b00};

  add4_slice u_slice (
    .a  (a_q[base +: NIBBLE_W]),
    .b  (b_q[base +: NIBBLE_W]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = op_sub ? ~B : B;
          carry_d = op_sub ? 1'b1 : cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d[base +: NIBBLE_W] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        // Flags are taken from the final slice pass so they land together with done.
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_co;
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (slice_s[NIBBLE_W-1] != a_q[MSB]);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16): vector table plus handshake,
// start-while-busy, reset-abort and rst/start-collision sequences.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  int unsigned n_cmp;
  int unsigned n_err;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .A      (A),
    .B      (B),
    .cin    (cin),
    .S      (S),
    .cout   (cout),
    .ovf    (ovf),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_s;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[8];

  // One cycle: outputs sampled / inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE, scramble inputs after acceptance, check latency and results.
  task automatic run_op(input string name, input logic sub, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic c,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int unsigned cyc;
    start  = 1'b1;
    op_sub = sub;
    A      = a;
    B      = b;
    cin    = c;
    tick();
    start  = 1'b0;
    A      = WIDTH'($urandom);
    B      = WIDTH'($urandom);
    cin    = ~c;
    op_sub = ~sub;
    cyc    = 1;
    chk({name, " busy@c1"}, 32'(busy), 32'd1);
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({name, " done cycle"}, cyc, 32'd5);
    chk({name, " S"}, 32'(S), 32'(es));
    chk({name, " cout"}, 32'(cout), 32'(ec));
    chk({name, " ovf"}, 32'(ovf), 32'(eo));
    chk({name, " busy@done"}, 32'(busy), 32'd1);
    tick();
    op_sub = 1'b0;
    cin    = 1'b0;
    chk({name, " done pulse width"}, 32'(done), 32'd0);
    chk({name, " busy after done"}, 32'(busy), 32'd0);
    chk({name, " S held"}, 32'(S), 32'(es));
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    A      = '0;
    B      = '0;
    cin    = 1'b0;

    vecs[0] = '{"add basic",      1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{"add full ripple", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"add cin",        1'b0, 16'hFFFE, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{"sub borrow",     1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{"sub ovf",        1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{"add ovf",        1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{"sub equal",      1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{"sub cin ignored", 1'b1, 16'h0003, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0};

    tick();
    tick();
    rst = 1'b0;
    chk("reset S", 32'(S), 32'd0);
    chk("reset cout", 32'(cout), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    tick();
    chk("idle no start busy", 32'(busy), 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op_sub, vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_ovf);

    // Starts at c2 (RUN) and c5 (DONE) are ignored; start at c6 (IDLE) is accepted.
    start = 1'b1; A = 16'h0001; B = 16'h0001; cin = 1'b0; op_sub = 1'b0;
    tick();                                   // c1
    start = 1'b0;
    tick();                                   // c2
    start = 1'b1; A = 16'hAAAA; B = 16'h1111;
    tick();                                   // c3
    start = 1'b0;
    tick();                                   // c4
    tick();                                   // c5
    chk("busy-start done@c5", 32'(done), 32'd1);
    chk("busy-start S@c5", 32'(S), 32'h0002);
    start = 1'b1;
    tick();                                   // c6
    chk("busy-start idle@c6", 32'(busy), 32'd0);
    chk("busy-start S@c6", 32'(S), 32'h0002);
    tick();                                   // c7
    start = 1'b0; A = '0; B = '0;
    chk("restart busy@c7", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) tick();       // c11
    chk("restart done@c11", 32'(done), 32'd1);
    chk("restart S", 32'(S), 32'hBBBB);
    tick();

    // Reset mid-RUN after an op that left cout=1, ovf=1.
    run_op("pre-abort", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    start = 1'b1; A = 16'h0010; B = 16'h0020;
    tick();                                   // c1
    start = 1'b0;
    tick();                                   // c2
    chk("flags held in RUN cout", 32'(cout), 32'd1);
    chk("flags held in RUN ovf", 32'(ovf), 32'd1);
    tick();                                   // c3
    rst = 1'b1;
    tick();                                   // c4
    rst = 1'b0;
    chk("abort S", 32'(S), 32'd0);
    chk("abort cout", 32'(cout), 32'd0);
    chk("abort ovf", 32'(ovf), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    begin
      int unsigned seen;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (done || busy) seen++;
      end
      chk("abort no done pulse", seen, 32'd0);
    end
    run_op("post-abort", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // rst and start together: rst wins.
    start = 1'b1; rst = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
    tick();
    start = 1'b0; rst = 1'b0;
    chk("rst+start busy", 32'(busy), 32'd0);
    tick();
    chk("rst+start busy later", 32'(busy), 32'd0);
    chk("rst+start S", 32'(S), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
